// File: rtl/ext_int_sched.sv
// External interrupt sequencer: edge/level detection, per-line pending latch,
// fixed-priority selection and a req/ack/eoi handshake towards the core.
module ext_int_sched #(
  parameter int N_INT = 31,
  parameter int ID_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_INT-1:0] ext_int_in_i,
  input  logic [N_INT-1:0] int_en_i,
  input  logic [N_INT-1:0] edge_mode_i,
  input  logic             int_ack_i,
  input  logic             eoi_i,
  output logic             int_req_o,
  output logic [ID_W-1:0]  int_id_o,
  output logic             busy_o,
  output logic [N_INT-1:0] pending_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e             state_q;
  logic [N_INT-1:0]   in_q;
  logic [N_INT-1:0]   in_q2;
  logic [N_INT-1:0]   pending_q;
  logic [N_INT-1:0]   pending_d;
  logic               int_req_q;
  logic               busy_q;
  logic [ID_W-1:0]    int_id_q;

  logic [N_INT-1:0]   rise;
  logic [N_INT-1:0]   cand;
  logic [N_INT-1:0]   id_onehot;
  logic [N_INT-1:0]   ack_clr;
  logic               ack_hit;
  logic               sel_live;
  logic [ID_W-1:0]    winner;

  // Lowest set index wins; line 0 has the highest priority.
  function automatic logic [ID_W-1:0] first_set(input logic [N_INT-1:0] v);
    logic [ID_W-1:0] r;
    r = {ID_W{1'b0}};
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = ID_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  always_comb begin
    rise      = in_q & ~in_q2;
    cand      = pending_q & int_en_i;
    winner    = first_set(cand);
    ack_hit   = (state_q == REQ) && int_ack_i;
    id_onehot = {N_INT{1'b0}};
    for (int i = 0; i < N_INT; i++) begin
      id_onehot[i] = (int_id_q == ID_W'(i));
    end
    ack_clr   = id_onehot & {N_INT{ack_hit}};
    sel_live  = |(cand & id_onehot);
    // Edge lines: a fresh rise beats a same-cycle ack clear. Level lines follow in_q.
    pending_d = {N_INT{1'b0}};
    for (int i = 0; i < N_INT; i++) begin
      if (edge_mode_i[i]) begin
        pending_d[i] = rise[i] | (pending_q[i] & ~ack_clr[i]);
      end else begin
        pending_d[i] = in_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      in_q      <= {N_INT{1'b0}};
      in_q2     <= {N_INT{1'b0}};
      pending_q <= {N_INT{1'b0}};
    end else begin
      in_q      <= ext_int_in_i;
      in_q2     <= in_q;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      int_req_q <= 1'b0;
      busy_q    <= 1'b0;
      int_id_q  <= {ID_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (|cand) begin
            int_id_q  <= winner;
            int_req_q <= 1'b1;
            state_q   <= REQ;
          end else begin
            int_id_q  <= {ID_W{1'b0}};
            int_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        REQ: begin
          // Ack takes precedence over withdrawal; no preemption while offered.
          if (int_ack_i) begin
            int_req_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SERVICE;
          end else if (!sel_live) begin
            int_req_q <= 1'b0;
            int_id_q  <= {ID_W{1'b0}};
            state_q   <= IDLE;
          end else begin
            int_req_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        SERVICE: begin
          int_req_q <= 1'b0;
          if (eoi_i) begin
            busy_q   <= 1'b0;
            int_id_q <= {ID_W{1'b0}};
            state_q  <= IDLE;
          end else begin
            busy_q   <= 1'b1;
            state_q  <= SERVICE;
          end
        end
        default: begin
          int_req_q <= 1'b0;
          busy_q    <= 1'b0;
          int_id_q  <= {ID_W{1'b0}};
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign int_req_o = int_req_q;
  assign int_id_o  = int_id_q;
  assign busy_o    = busy_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_ext_int_sched.sv
// Directed bench for ext_int_sched: linear stimulus with hand-computed expectations.
module tb_ext_int_sched;

  logic        clk;
  logic        rst_n;
  logic [30:0] ext;
  logic [30:0] en;
  logic [30:0] em;
  logic        ack;
  logic        eoi;
  logic        int_req;
  logic [4:0]  int_id;
  logic        busy;
  logic [30:0] pending;

  int n_assert = 0;
  int n_fail   = 0;

  ext_int_sched #(.N_INT(31), .ID_W(5)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .ext_int_in_i (ext),
    .int_en_i     (en),
    .edge_mode_i  (em),
    .int_ack_i    (ack),
    .eoi_i        (eoi),
    .int_req_o    (int_req),
    .int_id_o     (int_id),
    .busy_o       (busy),
    .pending_o    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // req, busy, id in one compare
  task automatic chk_out(input string tag, input logic r, input logic b, input logic [4:0] id);
    chk(tag, {57'd0, int_req, busy, int_id}, {57'd0, r, b, id});
  endtask

  initial begin
    rst_n = 1'b0;
    ext   = 31'h0;
    en    = 31'h7FFF_FFFF;
    em    = 31'h7FFF_FFDF;   // line 5 level, all others edge
    ack   = 1'b0;
    eoi   = 1'b0;
    tick();
    tick();
    chk_out("reset_out", 1'b0, 1'b0, 5'd0);
    chk("reset_pend", {33'd0, pending}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_out("idle_out", 1'b0, 1'b0, 5'd0);
      chk("idle_pend", {33'd0, pending}, 64'd0);
    end

    // Line 7 edge: latency and full handshake
    ext[7] = 1'b1;
    tick();
    chk("l7_k_pend", {33'd0, pending}, 64'd0);
    ext[7] = 1'b0;
    tick();
    chk("l7_k1_pend", {33'd0, pending}, 64'h80);
    chk_out("l7_k1_out", 1'b0, 1'b0, 5'd0);
    tick();
    chk_out("l7_req", 1'b1, 1'b0, 5'd7);
    tick();
    chk_out("l7_hold", 1'b1, 1'b0, 5'd7);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_out("l7_ack", 1'b0, 1'b1, 5'd7);
    chk("l7_ack_pend", {33'd0, pending}, 64'd0);
    tick();
    chk_out("l7_svc", 1'b0, 1'b1, 5'd7);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk_out("l7_eoi", 1'b0, 1'b0, 5'd0);
    tick();
    chk_out("l7_idle", 1'b0, 1'b0, 5'd0);

    // Stray ack/eoi in IDLE have no effect
    ack = 1'b1;
    eoi = 1'b1;
    tick();
    ack = 1'b0;
    eoi = 1'b0;
    chk_out("stray", 1'b0, 1'b0, 5'd0);

    // Lines 3 and 12 together: 3 first, 12 two cycles after eoi
    ext[3]  = 1'b1;
    ext[12] = 1'b1;
    tick();
    ext[3]  = 1'b0;
    ext[12] = 1'b0;
    tick();
    chk("p_3_12", {33'd0, pending}, 64'h1008);
    tick();
    chk_out("req3", 1'b1, 1'b0, 5'd3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_out("svc3", 1'b0, 1'b1, 5'd3);
    chk("p_12", {33'd0, pending}, 64'h1000);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk_out("eoi3", 1'b0, 1'b0, 5'd0);
    tick();
    chk_out("req12", 1'b1, 1'b0, 5'd12);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk_out("done12", 1'b0, 1'b0, 5'd0);
    chk("p_none", {33'd0, pending}, 64'd0);

    // Line 5 level held through eoi: re-offered
    ext[5] = 1'b1;
    tick();
    tick();
    tick();
    chk_out("req5", 1'b1, 1'b0, 5'd5);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("p5_after_ack", {33'd0, pending}, 64'h20);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk_out("eoi5", 1'b0, 1'b0, 5'd0);
    tick();
    chk_out("reoffer5", 1'b1, 1'b0, 5'd5);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    ext[5] = 1'b0;
    tick();
    tick();
    chk("p5_drop", {33'd0, pending}, 64'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    chk_out("no_reoffer5", 1'b0, 1'b0, 5'd0);
    tick();
    chk_out("no_reoffer5b", 1'b0, 1'b0, 5'd0);

    // Line 9: withdraw on disable, re-offer on enable
    ext[9] = 1'b1;
    tick();
    ext[9] = 1'b0;
    tick();
    tick();
    chk_out("req9", 1'b1, 1'b0, 5'd9);
    en[9] = 1'b0;
    tick();
    chk("wd9_req", {63'd0, int_req}, 64'd0);
    chk("wd9_pend", {33'd0, pending}, 64'h200);
    tick();
    chk("wd9_stay", {63'd0, int_req}, 64'd0);
    en[9] = 1'b1;
    tick();
    chk_out("reoffer9", 1'b1, 1'b0, 5'd9);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;

    // Line 2: new edge in the ack cycle survives the clear
    ext[2] = 1'b1;
    tick();
    ext[2] = 1'b0;
    tick();
    tick();
    chk_out("req2", 1'b1, 1'b0, 5'd2);
    ext[2] = 1'b1;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    ext[2] = 1'b0;
    chk_out("svc2", 1'b0, 1'b1, 5'd2);
    chk("p2_kept", {33'd0, pending}, 64'h4);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    chk_out("reoffer2", 1'b1, 1'b0, 5'd2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("p2_clr", {33'd0, pending}, 64'd0);
    chk_out("svc2b", 1'b0, 1'b1, 5'd2);

    // Reset while in SERVICE
    ext[20] = 1'b1;
    rst_n = 1'b0;
    tick();
    chk_out("rst_svc", 1'b0, 1'b0, 5'd0);
    chk("rst_pend", {33'd0, pending}, 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst_edge20", {33'd0, pending}, 64'h10_0000);
    tick();
    chk_out("req20", 1'b1, 1'b0, 5'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_int_sched.md
Name: ext_int_sched

Overview:
- Sequences the 31 external interrupt lines towards the core: edge/level detection, per-line pending latch, fixed-priority selection and a request/acknowledge/end-of-interrupt handshake.
- Sits between the registered external interrupt inputs and the CPU's interrupt entry logic.
- Exactly one interrupt is offered or in service at a time; there is no nesting.

Parameters:
- N_INT, 31, number of external interrupt lines.
- ID_W, 5, width of the interrupt id; must satisfy 2^ID_W >= N_INT.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- ext_int_in  input  N_INT  raw external interrupt levels, already synchronised to clk.
- int_en  input  N_INT  per-line enable; 1 = line may be selected.
- edge_mode  input  N_INT  per-line mode; 1 = rising-edge triggered, 0 = level (active high).
- int_ack  input  1  core accepts the offered interrupt; single-cycle pulse.
- eoi  input  1  core finished servicing; single-cycle pulse.
- int_req  output  1  interrupt offered to the core.
- int_id  output  ID_W  index of the offered or in-service line.
- busy  output  1  an interrupt is in service.
- pending  output  N_INT  current pending vector.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE; in_q, in_q2, pending, int_id cleared to 0; int_req = 0; busy = 0.
  - Applies from any state; an in-flight request or service is dropped with no ack or eoi needed.
  - Input history is cleared, so a line already high at reset release is seen as a rising edge.
- Input stage:
  - in_q <= ext_int_in and in_q2 <= in_q every cycle.
  - Rising edge on line i: rise[i] = in_q[i] & ~in_q2[i].
- Pending, edge lines (edge_mode[i] = 1):
  - Set on rise[i].
  - Cleared when int_ack is accepted while int_id == i.
  - A set and a clear in the same cycle: set wins, so the bit stays 1.
  - pending[i] is set independently of int_en[i].
- Pending, level lines (edge_mode[i] = 0):
  - pending[i] <= in_q[i] every cycle; ack does not clear it.
  - The source must drop its level before eoi, or it is re-offered.
- Latency: input rises before edge k -> in_q = 1 after edge k -> pending = 1 after edge k+1 -> int_req = 1 after edge k+2 (when IDLE). The same figures apply to both modes.
- Selection: cand = pending & int_en; the lowest index set in cand wins (fixed priority, line 0 highest).
- State machine (registered outputs):
  - IDLE:
    - int_req = 0, busy = 0, int_id = 0.
    - If cand != 0: latch int_id = winner, int_req <= 1, go to REQ.
  - REQ:
    - int_req = 1; int_id held stable.
    - int_ack = 1: int_req <= 0, busy <= 1, go to SERVICE.
    - Otherwise, if cand[int_id] == 0 (source disabled, or level source dropped): int_req <= 0, go to IDLE (request withdrawn).
    - If ack and withdraw conditions occur in the same cycle, ack wins.
    - A higher-priority line arriving during REQ does not preempt.
  - SERVICE:
    - busy = 1, int_req = 0, int_id held.
    - eoi = 1: busy <= 0, int_id <= 0, go to IDLE.
    - A new selection happens no earlier than the cycle after IDLE is entered.
- Ignored inputs: int_ack outside REQ; eoi outside SERVICE. Neither has any effect.
- Width rules: int_id is the zero-extended line index; if ID_W > needed width, the upper bits are 0.

Test Plan:
- Reset, all inputs 0, then rst_n = 1 -> int_req = 0, busy = 0, int_id = 0, pending = 0 for 20 cycles.
- Line 7, edge mode, enabled, input rises before edge k -> pending[7] = 1 after k+1; int_req = 1 with int_id = 7 after k+2; ack pulse -> int_req = 0, busy = 1, pending[7] = 0; eoi -> busy = 0, IDLE.
- Lines 3 and 12 pending simultaneously -> id 3 offered first; after ack and eoi, id 12 offered two cycles later.
- Line 5, level mode, held high through eoi -> re-offered with int_id = 5; level dropped before eoi -> no re-offer.
- REQ on line 9, then int_en[9] cleared before ack -> int_req drops the next cycle, pending[9] stays 1; re-enable -> re-offered.
- Edge on line 2 in the same cycle as ack of id 2 -> pending[2] remains 1 and is re-offered after eoi. Separately: rst_n asserted during SERVICE -> all outputs 0 the next cycle.
